// File: rtl/lw_sha_dma_pkg.sv
// Shared types and constants for the SHA AHB-Lite DMA master.
// Optional: FIQSHA_DMA_BSWAP_EN enables per-32-bit-lane byte swap.
package lw_sha_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_FINISH
  } state_t;

  localparam logic [1:0] STAT_OK     = 2'b00;
  localparam logic [1:0] STAT_BUSERR = 2'b01;
  localparam logic [1:0] STAT_ABORT  = 2'b10;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/lw_sha_dma_ptr.sv
// Source/destination pointers and remaining-word counter.
// Loaded at job start, advanced after each completed write beat.
module lw_sha_dma_ptr
  import lw_sha_dma_pkg::*;
#(
  parameter int          LEN_W = 16,
  parameter logic [31:0] STEP  = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic             i_adv_dst,
  input  logic [31:0]      i_src,
  input  logic [31:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
  output logic [31:0]      o_src,
  output logic [31:0]      o_dst,
  output logic [LEN_W-1:0] o_rem
);

  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_src <= i_src;
      r_dst <= i_dst;
      r_rem <= i_len;
    end else if (i_adv) begin
      r_src <= r_src + STEP;
      if (i_adv_dst)
        r_dst <= r_dst + STEP;
      r_rem <= r_rem - LEN_W'(1);
    end
  end

  assign o_src = r_src;
  assign o_dst = r_dst;
  assign o_rem = r_rem;

endmodule

// File: rtl/lw_sha_ahb_dma_master.sv
// AHB-Lite single-beat DMA master feeding/draining the SHA slave.
// Optional: FIQSHA_DMA_BSWAP_EN byte-swaps each 32-bit lane on capture.
module lw_sha_ahb_dma_master
  import lw_sha_dma_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          LEN_W        = 16,
  parameter logic [31:0] SHA_DIN_ADDR = 32'h0000_0100
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  mode_i,
  input  logic [31:0]           src_addr_i,
  input  logic [31:0]           dst_addr_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  dma_wr_req_i,
  input  logic                  dma_rd_req_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            status_o,
  output logic [LEN_W-1:0]      remaining_o,
  output logic [31:0]           haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  localparam logic [31:0] STEP = 32'(DATA_WIDTH / 8);

  state_t                r_state;
  state_t                w_next;
  logic                  r_mode;
  logic                  r_abt;
  logic [1:0]            r_status;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [31:0]           w_src;
  logic [31:0]           w_dst;
  logic [LEN_W-1:0]      w_rem;
  logic                  w_load;
  logic                  w_adv;
  logic                  w_abt;
  logic                  w_req;

  assign w_load = (r_state == S_IDLE) && start_i;
  assign w_adv  = (r_state == S_WR_DATA) && hready && !hresp;
  assign w_abt  = r_abt || abort_i;
  assign w_req  = r_mode ? dma_rd_req_i : dma_wr_req_i;

`ifdef FIQSHA_DMA_BSWAP_EN
  always_comb begin
    w_rdata = hrdata;
    for (int i = 0; i < DATA_WIDTH / 32; i++)
      w_rdata[i*32 +: 32] = bswap32(hrdata[i*32 +: 32]);
  end
`else
  assign w_rdata = hrdata;
`endif

  lw_sha_dma_ptr #(
    .LEN_W (LEN_W),
    .STEP  (STEP)
  ) u_ptr (
    .clk       (hclk),
    .rst       (hreset),
    .i_load    (w_load),
    .i_adv     (w_adv),
    .i_adv_dst (r_mode),
    .i_src     (src_addr_i),
    .i_dst     (dst_addr_i),
    .i_len     (len_i),
    .o_src     (w_src),
    .o_dst     (w_dst),
    .o_rem     (w_rem)
  );

  always_ff @(posedge hclk) begin
    if (hreset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start_i)
          w_next = (len_i == '0) ? S_FINISH : S_WAIT_REQ;
      S_WAIT_REQ:
        if (abort_i)    w_next = S_FINISH;
        else if (w_req) w_next = S_RD_ADDR;
      S_RD_ADDR:
        if (hready)       w_next = S_RD_DATA;
        else if (abort_i) w_next = S_FINISH;
      S_RD_DATA:
        if (hready)
          w_next = (hresp || w_abt) ? S_FINISH : S_WR_ADDR;
      S_WR_ADDR:
        if (hready)       w_next = S_WR_DATA;
        else if (abort_i) w_next = S_FINISH;
      S_WR_DATA:
        if (hready) begin
          if (hresp || w_abt || w_rem == LEN_W'(1))
            w_next = S_FINISH;
          else
            w_next = S_WAIT_REQ;
        end
      S_FINISH:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // An error in a data phase overrides any pending abort status.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_mode   <= 1'b0;
      r_abt    <= 1'b0;
      r_status <= STAT_OK;
      r_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (start_i) begin
            r_mode   <= mode_i;
            r_abt    <= 1'b0;
            r_status <= STAT_OK;
          end
        S_WAIT_REQ:
          if (abort_i) r_status <= STAT_ABORT;
        S_RD_ADDR, S_WR_ADDR:
          if (abort_i) begin
            if (hready) r_abt    <= 1'b1;
            else        r_status <= STAT_ABORT;
          end
        S_RD_DATA, S_WR_DATA: begin
          if (abort_i) r_abt <= 1'b1;
          if (hresp)
            r_status <= STAT_BUSERR;
          else if (hready && w_abt)
            r_status <= STAT_ABORT;
          if (r_state == S_RD_DATA && hready && !hresp)
            r_data <= w_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    haddr  = '0;
    if (r_state == S_RD_ADDR) begin
      htrans = HTRANS_NONSEQ;
      haddr  = w_src;
    end else if (r_state == S_WR_ADDR) begin
      htrans = HTRANS_NONSEQ;
      hwrite = 1'b1;
      haddr  = r_mode ? w_dst : SHA_DIN_ADDR;
    end
  end

  assign hwdata      = r_data;
  assign hsize       = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
  assign hburst      = HBURST_SINGLE;
  assign busy_o      = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done_o      = (r_state == S_FINISH);
  assign status_o    = r_status;
  assign remaining_o = w_rem;

endmodule

// File: tb/tb_lw_sha_ahb_dma_master.sv
// Scoreboard bench for lw_sha_ahb_dma_master with a wait/error AHB slave.
// Expected write data follows FIQSHA_DMA_BSWAP_EN when defined.
module tb_lw_sha_ahb_dma_master;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        start_i, abort_i, mode_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] len_i;
  logic        dma_wr_req_i, dma_rd_req_i;
  logic        busy_o, done_o;
  logic [1:0]  status_o;
  logic [15:0] remaining_o;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata, hrdata;
  logic        hready, hresp;

  lw_sha_ahb_dma_master dut (
    .hclk(hclk), .hreset(hreset), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
    .len_i(len_i), .dma_wr_req_i(dma_wr_req_i),
    .dma_rd_req_i(dma_rd_req_i), .busy_o(busy_o), .done_o(done_o),
    .status_o(status_o), .remaining_o(remaining_o), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] rem;
  } done_t;

  txn_t  txq[$];
  done_t dq[$];
  int    nchk = 0;
  int    npass = 0;
  int    done_seen = 0;

  int          waits = 0;
  bit          err_en = 0;
  logic [31:0] err_addr = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] d);
`ifdef FIQSHA_DMA_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic push_txn(input bit wr, input bit err,
                          input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = wr; t.err = err; t.addr = a; t.data = d;
    txq.push_back(t);
  endtask

  task automatic push_done(input logic [1:0] st, input logic [15:0] rem);
    done_t d;
    d.st = st; d.rem = rem;
    dq.push_back(d);
  endtask

  task automatic push_feed(input logic [31:0] src, input int n);
    for (int i = 0; i < n; i++) begin
      push_txn(0, 0, src + 32'(4 * i), mem(src + 32'(4 * i)));
      push_txn(1, 0, 32'h100, exp_wd(mem(src + 32'(4 * i))));
    end
  endtask

  task automatic start_job(input logic m, input logic [31:0] s,
                           input logic [31:0] d, input logic [15:0] n);
    mode_i = m; src_addr_i = s; dst_addr_i = d; len_i = n;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string n);
    int base;
    int k;
    base = done_seen;
    k = 0;
    while (done_seen == base && k < budget) begin
      step();
      k++;
    end
    if (done_seen == base) begin
      nchk++;
      $display("FAIL %s: no done_o within %0d cycles", n, budget);
    end
  endtask

  // AHB slave: zero or programmed wait states, two-cycle error response
  bit          s_dph = 0, s_wr = 0, s_err = 0, s_stage = 0;
  int          s_cnt = 0;
  logic [31:0] s_addr = 0;
  always begin : slave
    bit          rst, acc, fin, w;
    logic [31:0] a;
    @(negedge hclk);
    rst = hreset;
    acc = (htrans == 2'b10) && hready;
    fin = s_dph && hready;
    a   = haddr;
    w   = hwrite;
    @(posedge hclk);
    #1;
    if (rst) begin
      s_dph = 0; hready = 1'b1; hresp = 1'b0;
    end else begin
      if (fin) s_dph = 0;
      if (acc) begin
        s_dph = 1; s_wr = w; s_addr = a; s_cnt = waits; s_stage = 0;
        s_err = err_en && !w && (a == err_addr);
      end
      if (s_dph) begin
        hrdata = s_wr ? 32'h0 : mem(s_addr);
        if (s_err) begin
          hresp = 1'b1; hready = s_stage; s_stage = 1;
        end else begin
          hresp = 1'b0; hready = (s_cnt == 0);
          if (s_cnt > 0) s_cnt--;
        end
      end else begin
        hready = 1'b1; hresp = 1'b0;
      end
    end
  end

  // Monitor: pops expected bus beats and done events
  bit          m_dph = 0, m_wr = 0, m_first = 0, m_stable = 0;
  logic [31:0] m_addr = 0, m_wd0 = 0;
  always @(negedge hclk) begin : monitor
    txn_t        e;
    done_t       d;
    bit          ok;
    logic [31:0] act;
    if (hreset) begin
      m_dph = 0;
    end else begin
      if (m_dph) begin
        if (m_first) begin
          m_wd0 = hwdata; m_stable = 1; m_first = 0;
        end else if (hwdata !== m_wd0) m_stable = 0;
        if (hready) begin
          m_dph = 0;
          act = m_wr ? hwdata : hrdata;
          nchk++;
          if (txq.size() == 0) begin
            $display("FAIL unexpected_txn: wr=%0d addr=%h data=%h",
                     m_wr, m_addr, act);
          end else begin
            e = txq.pop_front();
            if (e.err)
              ok = hresp && !m_wr && (m_addr == e.addr);
            else
              ok = !hresp && (m_wr == e.wr) && (m_addr == e.addr) &&
                   (act == e.data) && (!m_wr || m_stable);
            if (ok) npass++;
            else $display({"FAIL txn: got wr=%0d addr=%h data=%h resp=%0d ",
                           "stable=%0d expected wr=%0d addr=%h data=%h err=%0d"},
                          m_wr, m_addr, act, hresp, m_stable,
                          e.wr, e.addr, e.data, e.err);
          end
        end
      end else if (htrans == 2'b10 && hready) begin
        m_dph = 1; m_wr = hwrite; m_addr = haddr; m_first = 1;
      end
      if (done_o) begin
        done_seen++;
        nchk++;
        if (dq.size() == 0) begin
          $display("FAIL unexpected_done: status=%b rem=%0d",
                   status_o, remaining_o);
        end else begin
          d = dq.pop_front();
          if (status_o == d.st && remaining_o == d.rem && !busy_o) npass++;
          else $display("FAIL done: got st=%b rem=%0d busy=%0d expected st=%b rem=%0d busy=0",
                        status_o, remaining_o, busy_o, d.st, d.rem);
        end
      end
    end
  end

  initial begin
    bit idle_ok;
    hreset = 1'b1; start_i = 0; abort_i = 0; mode_i = 0;
    src_addr_i = 0; dst_addr_i = 0; len_i = 0;
    dma_wr_req_i = 0; dma_rd_req_i = 0;
    hrdata = 0; hready = 1'b1; hresp = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_status", 32'(status_o), 0);
    chk("rst_rem", 32'(remaining_o), 0);
    chk("rst_htrans", 32'(htrans), 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hsize", 32'(hsize), 2);
    chk("rst_hburst", 32'(hburst), 0);
    hreset = 1'b0;
    step();

    // feed, 3 words, zero-wait, request held high
    push_feed(32'h2000, 3);
    push_done(2'b00, 0);
    dma_wr_req_i = 1;
    start_job(0, 32'h2000, 32'h0, 3);
    wait_done(100, "feed3");
    dma_wr_req_i = 0;
    chk("feed3_rem", 32'(remaining_o), 0);
    chk("feed3_status", 32'(status_o), 0);

    // throttle gaps of 5 cycles
    push_feed(32'h2100, 2);
    push_done(2'b00, 0);
    start_job(0, 32'h2100, 32'h0, 2);
    idle_ok = 1;
    repeat (5) begin step(); if (htrans != 2'b00) idle_ok = 0; end
    chk("thr_idle1", 32'(idle_ok), 1);
    dma_wr_req_i = 1;
    step();
    dma_wr_req_i = 0;
    chk("thr_nonseq1", {htrans, haddr[29:0]}, {2'b10, 30'h2100});
    repeat (4) step();
    idle_ok = 1;
    repeat (5) begin step(); if (htrans != 2'b00) idle_ok = 0; end
    chk("thr_idle2", 32'(idle_ok), 1);
    dma_wr_req_i = 1;
    step();
    dma_wr_req_i = 0;
    chk("thr_nonseq2", {htrans, haddr[29:0]}, {2'b10, 30'h2104});
    wait_done(100, "throttle");

    // drain, 8 words, 2 wait states
    waits = 2;
    for (int i = 0; i < 8; i++) begin
      push_txn(0, 0, 32'h40 + 32'(4 * i), mem(32'h40 + 32'(4 * i)));
      push_txn(1, 0, 32'h3000 + 32'(4 * i), exp_wd(mem(32'h40 + 32'(4 * i))));
    end
    push_done(2'b00, 0);
    dma_rd_req_i = 1;
    start_job(1, 32'h40, 32'h3000, 8);
    wait_done(1000, "drain8");
    dma_rd_req_i = 0;
    waits = 0;

    // bus error on the second read
    err_en = 1; err_addr = 32'h5004;
    push_txn(0, 0, 32'h5000, mem(32'h5000));
    push_txn(1, 0, 32'h100, exp_wd(mem(32'h5000)));
    push_txn(0, 1, 32'h5004, 32'h0);
    push_done(2'b01, 3);
    dma_wr_req_i = 1;
    start_job(0, 32'h5000, 32'h0, 4);
    wait_done(100, "buserr");
    dma_wr_req_i = 0;
    err_en = 0;
    chk("err_status", 32'(status_o), 1);
    chk("err_rem", 32'(remaining_o), 3);

    // abort in WAIT_REQ after 2 of 4 words, then a normal job
    push_feed(32'h6000, 2);
    push_done(2'b10, 2);
    start_job(0, 32'h6000, 32'h0, 4);
    repeat (2) begin
      dma_wr_req_i = 1;
      step();
      dma_wr_req_i = 0;
      repeat (4) step();
    end
    chk("abt_rem_before", 32'(remaining_o), 2);
    abort_i = 1;
    step();
    abort_i = 0;
    chk("abt_done", 32'(done_o), 1);
    step();
    chk("abt_status", 32'(status_o), 2);
    push_feed(32'h6100, 1);
    push_done(2'b00, 0);
    dma_wr_req_i = 1;
    start_job(0, 32'h6100, 32'h0, 1);
    wait_done(100, "after_abort");
    dma_wr_req_i = 0;
    chk("after_abt_status", 32'(status_o), 0);

    // start while busy is ignored
    push_feed(32'h7000, 2);
    push_done(2'b00, 0);
    dma_wr_req_i = 1;
    dma_rd_req_i = 1;
    start_job(0, 32'h7000, 32'h0, 2);
    step();
    start_job(1, 32'h9000, 32'h9100, 5);
    wait_done(100, "busy_start");
    dma_wr_req_i = 0;
    dma_rd_req_i = 0;
    chk("busy_start_rem", 32'(remaining_o), 0);

    // len = 0
    push_done(2'b00, 0);
    start_job(0, 32'hA000, 32'h0, 0);
    chk("len0_done", 32'(done_o), 1);
    chk("len0_htrans", 32'(htrans), 0);
    step();
    step();

    // reset in the middle of RD_DATA
    waits = 3;
    dma_wr_req_i = 1;
    start_job(0, 32'h8000, 32'h0, 2);
    step();
    step();
    chk("mid_busy", 32'(busy_o), 1);
    hreset = 1'b1;
    step();
    chk("mrst_busy", 32'(busy_o), 0);
    chk("mrst_done", 32'(done_o), 0);
    chk("mrst_status", 32'(status_o), 0);
    chk("mrst_rem", 32'(remaining_o), 0);
    chk("mrst_htrans", 32'(htrans), 0);
    chk("mrst_hwrite", 32'(hwrite), 0);
    chk("mrst_haddr", haddr, 0);
    chk("mrst_hwdata", hwdata, 0);
    hreset = 1'b0;
    dma_wr_req_i = 0;
    waits = 0;

    repeat (5) step();
    chk("txq_empty", 32'(txq.size()), 0);
    chk("dq_empty", 32'(dq.size()), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/lw_sha_ahb_dma_master.md
Name: lw_sha_ahb_dma_master

Overview:
- AHB-Lite initiator (DMA channel) on the far end of the SHA slave's dma_wr_req/dma_rd_req lines.
- Feed mode: copies message words from system memory into the SHA data-in register, one word per asserted dma_wr_req.
- Drain mode: copies hash/readout words from the SHA slave to memory, throttled by dma_rd_req.
- Non-pipelined, single-beat transfers. Configured by a register block through start/len/address ports.

Parameters:
- DATA_WIDTH, 32, AHB data width and word size; 32 or 64.
- LEN_W, 16, width of the word-count field.
- SHA_DIN_ADDR, 32'h0000_0100, fixed destination address of the SHA data-in register in feed mode.

Ports:
- hclk  in  1  clock
- hreset  in  1  synchronous active-high reset
- start_i  in  1  one-cycle job launch; ignored while busy_o=1
- abort_i  in  1  one-cycle abort request
- mode_i  in  1  0 = feed (mem->SHA), 1 = drain (SHA->mem); sampled at start
- src_addr_i  in  32  source start address, word aligned; sampled at start
- dst_addr_i  in  32  destination start address; drain mode only; sampled at start
- len_i  in  LEN_W  number of words; sampled at start
- dma_wr_req_i  in  1  SHA ready to accept a word (feed throttle)
- dma_rd_req_i  in  1  SHA has a word to read (drain throttle)
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse at job end
- status_o  out  2  00 ok, 01 bus error, 10 aborted; held until next accepted start
- remaining_o  out  LEN_W  words left
- haddr  out  32  AHB address
- htrans  out  2  IDLE (00) or NONSEQ (10) only
- hwrite  out  1  AHB write
- hsize  out  3  log2(DATA_WIDTH/8)
- hburst  out  3  constant SINGLE (000)
- hwdata  out  DATA_WIDTH  write data
- hrdata  in  DATA_WIDTH  read data
- hready  in  1  transfer ready
- hresp  in  1  error response

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - busy_o=0, done_o=0, status_o=00, remaining_o=0.
  - htrans=IDLE, hwrite=0, haddr=0, hwdata=0.
  - FSM in IDLE.
- FSM states: IDLE, WAIT_REQ, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, FINISH.
- IDLE:
  - start_i with len_i=0: FINISH directly, status 00, no bus activity.
  - start_i with len_i>0: latch inputs, remaining_o=len_i, busy_o=1, go to WAIT_REQ.
- WAIT_REQ: wait for the throttle line (dma_wr_req_i in feed mode, dma_rd_req_i in drain mode). On assertion, go to RD_ADDR.
- RD_ADDR:
  - Drive htrans=NONSEQ, hwrite=0, haddr=src.
  - Feed mode: src = memory pointer. Drain mode: src = SHA readout pointer.
  - Advance to RD_DATA in the cycle hready=1. Outputs hold while hready=0.
- RD_DATA: htrans=IDLE.
  - hready=1 and hresp=0: capture hrdata into the data register, go to WR_ADDR.
  - hresp=1 (either cycle of the two-cycle error response): set status 01, go to FINISH once hready=1.
- WR_ADDR:
  - Drive NONSEQ, hwrite=1.
  - haddr = SHA_DIN_ADDR in feed mode; haddr = dst pointer in drain mode.
  - Advance on hready=1.
- WR_DATA:
  - hwdata = data register, held stable for the whole data phase.
  - On hready=1 with hresp=0: src += DATA_WIDTH/8, dst += DATA_WIDTH/8 (drain mode only), remaining_o decrements.
  - remaining reaches 0: FINISH. Otherwise: WAIT_REQ.
  - Error handling is the same as in RD_DATA.
- Pointers wrap modulo 2^32; no 1 KB boundary check is required, because all transfers are SINGLE.
- FINISH: done_o=1 for one cycle, busy_o=0, return to IDLE.
- abort_i:
  - In IDLE: ignored.
  - In WAIT_REQ or RD_ADDR: FINISH next cycle. Caveat: if RD_ADDR's address is being accepted in that same cycle (hready=1), complete that data phase first.
  - Mid data phase: finish the current data phase, then FINISH.
  - Status 10 in all cases, unless a bus error occurs in the same data phase; the error wins.
  - remaining_o keeps its value.
- start_i together with abort_i in IDLE: start wins.
- A throttle line dropping after a word begins has no effect on that word.
- Reset mid-transfer: immediate return to reset values. The bus is left IDLE, which is legal under AHB-Lite.

Optional Feature:
- FIQSHA_DMA_BSWAP_EN defined:
  - A mode-independent byte swap is applied in the data register. Each 32-bit lane's bytes are reversed.
  - For DATA_WIDTH=64, each 32-bit half is swapped independently.
  - Purpose: little-endian memory feeding the big-endian SHA word order.
- Undefined: data passes unmodified. Zero logic is added.

Decomposition:
- Shared package lw_sha_dma_pkg:
  - FSM state enum.
  - Status codes (STAT_OK, STAT_BUSERR, STAT_ABORT).
  - HTRANS_IDLE/HTRANS_NONSEQ constants.
  - HBURST_SINGLE constant.
  - bswap32 function.
- One natural sub-module, lw_sha_dma_ptr: src/dst address and remaining-count registers with load, increment and decrement.

Test Plan:
- Feed mode: len=3, src=0x2000, dma_wr_req_i held high, zero-wait slave.
  - Required: reads at 0x2000, 0x2004, 0x2008, each followed by a write to 0x100.
  - Words written in order; done_o once; status 00; remaining_o 0.
- Throttle: dma_wr_req_i low for 5 cycles between words.
  - Required: htrans stays IDLE in WAIT_REQ.
  - Next NONSEQ appears exactly 1 cycle after the req rises.
- Drain mode: len=8, src=0x040, dst=0x3000, 2-wait-state slave, dma_rd_req_i high.
  - Required: 8 read/write pairs with dst 0x3000..0x301C.
  - hwdata stable through the wait states.
- Bus error on the 2nd read.
  - Required: status 01; done_o pulse; remaining_o=len-1.
  - No write issued for the failing word.
- Abort in WAIT_REQ after 2 of 4 words.
  - Required: done_o within 1 cycle; status 10; remaining_o=2.
  - A start accepted afterward runs normally.
- Boundary cases:
  - len=0: done_o next cycle, zero bus transfers.
  - start_i while busy: ignored.
  - Reset mid RD_DATA: all outputs return to reset values in the following cycle.
